keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4-row x 3-column matrix keypad and debounces it.
- Drives one column low at a time and samples the active-low rows.
- Outputs a stable 4-bit key code plus a one-cycle press strobe.
- Sits directly upstream of the menu text stage: its `key` output feeds that stage's `key[3:0]` input.

Parameters:
- SCAN_DIV, 65000: clock cycles each column is driven. Minimum 4, so the row synchronizer settles. At 65 MHz this is 1 ms.
- DEBOUNCE_FRAMES, 4: consecutive identical full-matrix frames required before `key` updates. Range 1..15.

Ports:
- clk  input  1  system pixel clock.
- rst  input  1  synchronous reset, active-low. Sampled on posedge clk; asserted when 0.
- row  input  4  keypad rows, active-low, external pull-ups, asynchronous to clk.
- col  output 3  keypad column drive, one-hot active-low.
- key  output 4  debounced key code; KEY_NONE when no key is pressed.
- key_strobe  output 1  one-cycle pulse when `key` changes to a value other than KEY_NONE.

Behaviour:
- Reset (rst=0 at posedge) gives:
  - col=3'b110; key=KEY_NONE (4'hF); key_strobe=0.
  - Column index 0; dwell counter 0; frame accumulator cleared; candidate=KEY_NONE; stable count 0; FSM in SCAN.
  - Reset asserted mid-debounce discards all progress.
- Row input: two-flop synchronizer on `row`. All decisions use the synchronized value.
- FSM states:
  - SCAN: the dwell counter counts 0..SCAN_DIV-1 with column c driven.
    - At count SCAN_DIV-1, latch the synchronized rows for column c into the frame accumulator.
    - If c<2, go to c+1 next cycle (col updates that cycle) and reset the counter.
    - If c=2, go to EVAL.
  - EVAL: one cycle. Compute frame_code, update the debouncer, return to SCAN with c=0 and col=3'b110.
  - Frame length is 3*SCAN_DIV+1 cycles.
- Key map: row r, column c →
  - r0: 1, 2, 3.
  - r1: 4, 5, 6.
  - r2: 7, 8, 9.
  - r3: * (KEY_ESC=4'hA), 0 (4'h0), # (KEY_ENT=4'hB).
  - Digits encode as their value.
- frame_code rules:
  - Exactly one asserted position in the frame: that key's code.
  - Zero asserted positions: KEY_NONE.
  - Two or more asserted positions (multi-press or ghosting): KEY_NONE.
- Debouncer, updated in EVAL:
  - If frame_code == candidate, stable count increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise candidate <= frame_code and stable count <= 1.
  - Let the effective count be the post-update value. When it equals DEBOUNCE_FRAMES and candidate != key: key <= candidate.
  - In that same update, key_strobe <= 1 if candidate != KEY_NONE; key_strobe is 0 in all other cycles.
  - A held key produces exactly one strobe. Release gives key=KEY_NONE with no strobe.
  - A direct change from key A to key B (without a KEY_NONE frame in between) strobes once for B.
- Latency: with a key stable from the start of a frame, key/key_strobe change at the clock edge ending the DEBOUNCE_FRAMES-th EVAL. Add up to one extra frame for an unaligned press, plus 2 cycles of synchronizer delay.
- Widths: the dwell counter is $clog2(SCAN_DIV) bits, and wraps only via explicit reset to 0.

Decomposition:
- vga_pkg holds KEY_0..KEY_9, KEY_ESC=4'hA, KEY_ENT=4'hB, KEY_NONE=4'hF. The existing key_2/key_3/key_4/key_esc aliases map onto these.
- Sub-module keypad_debounce: candidate/count/key/strobe logic. Inputs: clk, rst, frame_valid (EVAL), frame_code. Outputs: key, key_strobe.
- Top-level keypad_scanner contains the synchronizer, column FSM, and encoder.

Test Plan:
All scenarios use SCAN_DIV=8, DEBOUNCE_FRAMES=3, so a frame is 25 cycles.
1. Reset: drive rst=0 for 3 cycles, rows=4'hF → col=3'b110, key=4'hF, key_strobe=0. After release, col sequence is 110, 101, 011, with each value held 8 cycles and 110 held for 9 including EVAL.
2. Press '2': pull row0 low whenever col==3'b101, held for 5 frames → key=4'h2 at the end of EVAL #3 (≤100 cycles after press); exactly one key_strobe pulse; key stays 2.
3. Bounce: present '4' on alternating frames for 6 frames → key stays 4'hF; key_strobe is never asserted.
4. Ghost: '1' and '5' pressed together for 5 frames → key stays 4'hF, no strobe. Then release '5' → key=4'h1 after 3 frames, one strobe.
5. Press then release '*': key=4'hA with one strobe; after release, key=4'hF after 3 clean frames with no strobe. A direct '*'→'#' change gives key=4'hB with one strobe.
6. Reset mid-debounce: press '3' held for 2 frames, pulse rst=0 for 1 cycle, keep '3' held → key stays 4'hF until 3 full frames after reset, then becomes 4'h3 with one strobe.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared key codes, scanner states and the row/column to key-code map.
package keypad_scanner_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_ESC  = 4'hA;
  localparam logic [3:0] KEY_ENT  = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic {
    ST_SCAN,
    ST_EVAL
  } scan_state_t;

  // Rows 0..2 hold digits 1..9 in reading order; row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_at(input int r, input int c);
    logic [3:0] code;
    if (r == 3) begin
      case (c)
        0:       code = KEY_ESC;
        1:       code = KEY_0;
        default: code = KEY_ENT;
      endcase
    end else begin
      code = 4'(r * 3 + c + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix wiring plus the debounced key output towards the menu stage.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] key;
  logic       key_strobe;

  modport master (input row, output col, output key, output key_strobe);
  modport slave  (output row, input col, input key, input key_strobe);
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a key code must repeat DEBOUNCE_FRAMES times before it is published.
module keypad_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_valid,
  input  logic [3:0] frame_code,
  output logic [3:0] key,
  output logic       key_strobe
);

  localparam logic [3:0] FRAMES = 4'(DEBOUNCE_FRAMES);

  logic [3:0] cand_reg, cand_next;
  logic [3:0] count_reg, count_next;
  logic [3:0] key_reg, key_next;
  logic       strobe_reg, strobe_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cand_reg   <= KEY_NONE;
      count_reg  <= 4'd0;
      key_reg    <= KEY_NONE;
      strobe_reg <= 1'b0;
    end else begin
      cand_reg   <= cand_next;
      count_reg  <= count_next;
      key_reg    <= key_next;
      strobe_reg <= strobe_next;
    end
  end

  always_comb begin
    cand_next   = cand_reg;
    count_next  = count_reg;
    key_next    = key_reg;
    strobe_next = 1'b0;
    if (frame_valid) begin
      if (frame_code == cand_reg) begin
        if (count_reg < FRAMES) count_next = count_reg + 4'd1;
      end else begin
        cand_next  = frame_code;
        count_next = 4'd1;
      end
      // Decide on the post-update count so a new key lands on its final frame.
      if (count_next == FRAMES && cand_next != key_reg) begin
        key_next    = cand_next;
        strobe_next = (cand_next != KEY_NONE);
      end
    end
  end

  assign key        = key_reg;
  assign key_strobe = strobe_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row synchronizer, column-walk FSM and frame encoder feeding the debouncer.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV        = 65000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master bus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]      row_meta_reg, row_sync_reg;
  scan_state_t     state_reg, state_next;
  logic [1:0]      col_idx_reg, col_idx_next;
  logic [DW-1:0]   dwell_reg, dwell_next;
  logic [2:0][3:0] frame_reg, frame_next;
  logic            frame_valid;
  logic [3:0]      frame_code;
  logic [3:0]      hit_count;
  logic [3:0]      hit_code;

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      row_meta_reg <= bus.row;
      row_sync_reg <= row_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_SCAN;
      col_idx_reg <= 2'd0;
      dwell_reg   <= '0;
      frame_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      col_idx_reg <= col_idx_next;
      dwell_reg   <= dwell_next;
      frame_reg   <= frame_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    col_idx_next = col_idx_reg;
    dwell_next   = dwell_reg;
    frame_next   = frame_reg;
    frame_valid  = 1'b0;
    case (state_reg)
      ST_SCAN: begin
        if (dwell_reg == DWELL_LAST) begin
          frame_next[col_idx_reg] = ~row_sync_reg;
          dwell_next              = '0;
          if (col_idx_reg == 2'd2) begin
            // Column 0 is already driven during EVAL so its dwell runs one cycle long.
            col_idx_next = 2'd0;
            state_next   = ST_EVAL;
          end else begin
            col_idx_next = col_idx_reg + 2'd1;
          end
        end else begin
          dwell_next = dwell_reg + DW'(1);
        end
      end
      ST_EVAL: begin
        frame_valid = 1'b1;
        state_next  = ST_SCAN;
      end
      default: state_next = ST_SCAN;
    endcase
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_col
    assign bus.col[gi] = (col_idx_reg != 2'(gi));
  end

  // Multi-press and ghosting both show up as more than one hit and are rejected.
  always_comb begin
    hit_count = 4'd0;
    hit_code  = KEY_NONE;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (frame_reg[c][r]) begin
          hit_count = hit_count + 4'd1;
          hit_code  = key_at(r, c);
        end
      end
    end
    frame_code = (hit_count == 4'd1) ? hit_code : KEY_NONE;
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_valid(frame_valid),
    .frame_code (frame_code),
    .key        (bus.key),
    .key_strobe (bus.key_strobe)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a physical keypad model drives the rows, a frame-history model predicts outputs.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  localparam int SCAN_DIV = 8;
  localparam int DF       = 3;
  localparam int FRAME    = 3 * SCAN_DIV + 1;

  localparam logic [11:0] P_1    = 12'h001;
  localparam logic [11:0] P_2    = 12'h002;
  localparam logic [11:0] P_3    = 12'h004;
  localparam logic [11:0] P_4    = 12'h008;
  localparam logic [11:0] P_5    = 12'h010;
  localparam logic [11:0] P_STAR = 12'h200;
  localparam logic [11:0] P_HASH = 12'h800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] pressed = '0;  // bit r*3+c set means the key at row r, column c is held

  keypad_scanner_if bus ();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_FRAMES(DF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // A held key shorts its row to the driven-low column.
  always_comb begin
    bus.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && bus.col[c] == 1'b0) bus.row[r] = 1'b0;
  end

  int         errors  = 0;
  int         checks  = 0;
  int         strobes = 0;
  int         k       = 0;
  logic [3:0] m_key    = KEY_NONE;
  logic       m_strobe = 1'b0;
  logic [3:0] hist[$];

  function automatic logic [3:0] model_code(input logic [11:0] p);
    logic [3:0] lut [12];
    lut = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};
    if ($countones(p) != 1) return KEY_NONE;
    for (int i = 0; i < 12; i++) if (p[i]) return lut[i];
    return KEY_NONE;
  endfunction

  function automatic logic [2:0] exp_col(input int p);
    if (p < SCAN_DIV || p == 3 * SCAN_DIV) return 3'b110;
    if (p < 2 * SCAN_DIV) return 3'b101;
    return 3'b011;
  endfunction

  // Model: cycle position within the frame, plus a window of the last DF frame codes.
  initial begin
    logic [3:0] fc;
    bit         same;
    forever begin
      @(posedge clk);
      m_strobe = 1'b0;
      if (!rst) begin
        k     = 0;
        m_key = KEY_NONE;
        hist.delete();
      end else begin
        if (k % FRAME == FRAME - 1) begin
          fc = model_code(pressed);
          hist.push_back(fc);
          if (hist.size() > DF) void'(hist.pop_front());
          same = (hist.size() == DF);
          foreach (hist[i]) if (hist[i] != fc) same = 1'b0;
          if (same && fc != m_key) begin
            m_key    = fc;
            m_strobe = (fc != KEY_NONE);
          end
        end
        k++;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("col", {5'b0, bus.col}, {5'b0, exp_col(k % FRAME)});
    check("key", {4'b0, bus.key}, {4'b0, m_key});
    check("key_strobe", {7'b0, bus.key_strobe}, {7'b0, m_strobe});
    if (bus.key_strobe === 1'b1) strobes++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) tick();
    rst = 1'b1;
  endtask

  task automatic apply(input logic [11:0] set, input int nframes);
    pressed = set;
    repeat (nframes * FRAME) tick();
  endtask

  initial begin
    int s0;
    int lat;

    // Reset state and column walk
    pressed = '0;
    do_reset(3);
    check("reset_col", {5'b0, bus.col}, 8'h06);
    check("reset_key", {4'b0, bus.key}, 8'h0F);
    check("reset_strobe", {7'b0, bus.key_strobe}, 8'h00);
    $display("reset: col=%b key=%h", bus.col, bus.key);
    repeat (SCAN_DIV) tick();
    check("walk_col1", {5'b0, bus.col}, 8'h05);
    repeat (SCAN_DIV) tick();
    check("walk_col2", {5'b0, bus.col}, 8'h03);
    repeat (SCAN_DIV) tick();
    check("walk_eval_col", {5'b0, bus.col}, 8'h06);
    tick();
    check("walk_frame_wrap", {5'b0, bus.col}, 8'h06);
    $display("column walk: one frame done, key=%h", bus.key);

    // Press '2'
    do_reset(2);
    s0 = strobes;
    pressed = P_2;
    lat = -1;
    for (int i = 0; i < 5 * FRAME; i++) begin
      tick();
      if (lat < 0 && bus.key == KEY_2) lat = i + 1;
    end
    check("press2_latency_ok", {7'b0, (lat > 0 && lat <= 100)}, 8'h01);
    check("press2_key", {4'b0, bus.key}, 8'h02);
    check("press2_strobes", 8'(strobes - s0), 8'd1);
    $display("press '2': key=%h latency=%0d strobes=%0d", bus.key, lat, strobes - s0);

    // Bouncing '4'
    do_reset(2);
    s0 = strobes;
    for (int f = 0; f < 6; f++) apply((f % 2 == 0) ? P_4 : 12'h000, 1);
    check("bounce_key", {4'b0, bus.key}, 8'h0F);
    check("bounce_strobes", 8'(strobes - s0), 8'd0);
    $display("bounce '4': key=%h strobes=%0d", bus.key, strobes - s0);

    // Ghosting '1'+'5', then '1' alone
    do_reset(2);
    s0 = strobes;
    apply(P_1 | P_5, 5);
    check("ghost_key", {4'b0, bus.key}, 8'h0F);
    check("ghost_strobes", 8'(strobes - s0), 8'd0);
    apply(P_1, DF);
    check("ghost_release_key", {4'b0, bus.key}, 8'h01);
    check("ghost_release_strobes", 8'(strobes - s0), 8'd1);
    $display("ghost '1'+'5' then '1': key=%h strobes=%0d", bus.key, strobes - s0);

    // '*' press/release, then '*' -> '#' directly
    do_reset(2);
    s0 = strobes;
    apply(P_STAR, DF);
    check("star_key", {4'b0, bus.key}, 8'h0A);
    check("star_strobes", 8'(strobes - s0), 8'd1);
    apply(12'h000, DF);
    check("release_key", {4'b0, bus.key}, 8'h0F);
    check("release_strobes", 8'(strobes - s0), 8'd1);
    apply(P_STAR, DF);
    apply(P_HASH, DF);
    check("hash_key", {4'b0, bus.key}, 8'h0B);
    check("hash_strobes", 8'(strobes - s0), 8'd3);
    $display("'*' / release / '*'->'#': key=%h strobes=%0d", bus.key, strobes - s0);

    // Reset mid-debounce with '3' held
    do_reset(2);
    s0 = strobes;
    apply(P_3, 2);
    repeat (10) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    apply(P_3, 2);
    check("midreset_key_early", {4'b0, bus.key}, 8'h0F);
    apply(P_3, 1);
    check("midreset_key", {4'b0, bus.key}, 8'h03);
    check("midreset_strobes", 8'(strobes - s0), 8'd1);
    $display("reset mid-debounce '3': key=%h strobes=%0d", bus.key, strobes - s0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
